ula_div_seq: RTL and testbench

Sequential 32-bit unsigned restoring divider for the ULA. It is a controller that drives one shared instance of the ripple subtractor `full_adder_32bit_sub` for 32 iterations, one trial subtraction per clock, and produces quotient and remainder. Operands enter through a valid/ready start handshake and results leave through a valid/ready result handshake, so the block sits beside the combinational ALU path for divide opcodes.

---
 rtl/ula_div_pkg.sv | 15 +
 rtl/full_adder_32bit_sub.sv | 24 ++
 rtl/ula_div_seq.sv | 102 ++++++++++
 tb/tb_ula_div_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ula_div_pkg.sv
// rtl/ula_div_pkg.sv - shared types and constants for the sequential ULA divider
package ula_div_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 5;

    localparam logic [DIV_W-1:0] DZ_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/full_adder_32bit_sub.sv
// rtl/full_adder_32bit_sub.sv - 32-bit ripple subtractor, s = a - b, s[32]=1 means no borrow
module full_adder_32bit_sub
    import ula_div_pkg::*;
(
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic [DIV_W:0]   s
);

    logic [DIV_W-1:0] nb;
    logic [DIV_W:0]   c;

    // a + ~b + 1: the final carry-out is the inverted borrow
    assign nb   = ~b;
    assign c[0] = 1'b1;

    for (genvar i = 0; i < DIV_W; i++) begin : g_bit
        assign s[i]   = a[i] ^ nb[i] ^ c[i];
        assign c[i+1] = (a[i] & nb[i]) | (a[i] & c[i]) | (nb[i] & c[i]);
    end

    assign s[DIV_W] = c[DIV_W];

endmodule

// File: rtl/ula_div_seq.sv
// rtl/ula_div_seq.sv - 32-cycle unsigned restoring divider with start/result handshakes
module ula_div_seq
    import ula_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] r, q, d;
    logic [DIV_W-1:0] t, r_nxt, q_nxt;
    logic [DIV_W:0]   s;
    logic             take;
    logic             last_iter;
    logic             start_hs;

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);
    assign start_hs     = start_valid & start_ready;
    assign last_iter    = &cnt;

    // Shift in the next dividend bit; a set R msb means the 33-bit value already exceeds D
    assign t = {r[DIV_W-2:0], q[DIV_W-1]};

    full_adder_32bit_sub u_sub (
        .a (t),
        .b (d),
        .s (s)
    );

    assign take  = r[DIV_W-1] | s[DIV_W];
    assign r_nxt = take ? s[DIV_W-1:0] : t;
    assign q_nxt = {q[DIV_W-2:0], take};

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_hs) state_nxt = (divisor == '0) ? DONE : CALC;
                CALC:    if (last_iter) state_nxt = DONE;
                DONE:    if (result_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                div_by_zero <= 1'b0;
            end else if (state == IDLE && start_hs) begin
                if (divisor == '0) begin
                    quotient    <= DZ_QUOT;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end else begin
                    d   <= divisor;
                    q   <= dividend;
                    r   <= '0;
                    cnt <= '0;
                end
            end else if (state == CALC) begin
                r   <= r_nxt;
                q   <= q_nxt;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    quotient    <= q_nxt;
                    remainder   <= r_nxt;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_div_seq.sv
// tb/tb_ula_div_seq.sv - directed self-checking bench for ula_div_seq
module tb_ula_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ula_div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept operands, count edges until result_valid, check results, then retire
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz,
                           input int elat);
        int  lat;
        bit  sr_low;
        chk({tag, ".ready_before"}, start_ready, 1'b1);
        start_valid = 1'b1;
        dividend    = a;
        divisor     = b;
        tick();
        start_valid = 1'b0;
        dividend    = 32'h0;
        divisor     = 32'h0;
        lat    = 0;
        sr_low = 1'b1;
        while (!result_valid && lat < 100) begin
            if (start_ready) sr_low = 1'b0;
            tick();
            lat++;
        end
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".start_ready_low"}, sr_low, 1'b1);
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".dz"}, div_by_zero, edz);
        chk({tag, ".busy"}, busy, 1'b1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, ".idle_after"}, {result_valid, start_ready, busy}, 3'b010);
    endtask

    initial begin
        int  lat;
        bit  stable;
        bit  seen;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        dividend     = 32'h0;
        divisor      = 32'h0;
        flush        = 1'b0;
        result_ready = 1'b0;
        #12;
        chk("reset.outs", {quotient, remainder, div_by_zero, result_valid, busy, start_ready},
            {32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_div("d100_7",  32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 32);
        run_div("dmax_1",  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'h0,         1'b0, 32);
        run_div("dmsb",    32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0, 32);
        run_div("dsmall",  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 32);
        run_div("dz5",     32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 0);
        run_div("d1000",   32'd1000,      32'd10,        32'd100,       32'd0,         1'b0, 32);
        run_div("dlt",     32'd7,         32'd100,       32'd0,         32'd7,         1'b0, 32);

        // Backpressure with start_valid held high
        start_valid = 1'b1;
        dividend    = 32'd100;
        divisor     = 32'd7;
        tick();
        dividend = 32'd9;
        divisor  = 32'd3;
        lat = 0;
        while (!result_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("bp.latency", lat, 32);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (quotient !== 32'd14 || remainder !== 32'd2 || !result_valid || start_ready)
                stable = 1'b0;
        end
        chk("bp.stable", stable, 1'b1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        start_valid  = 1'b0;
        chk("bp.retire", {result_valid, start_ready, busy}, 3'b010);
        tick();
        chk("bp.no_accept", busy, 1'b0);

        // Flush at iteration 10
        start_valid = 1'b1;
        dividend    = 32'd1000;
        divisor     = 32'd10;
        tick();
        start_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.idle", {result_valid, start_ready, busy, div_by_zero}, 4'b0100);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid || busy) seen = 1'b1;
        end
        chk("flush.no_result", seen, 1'b0);

        // Flush clears div_by_zero while in DONE
        start_valid = 1'b1;
        dividend    = 32'd5;
        divisor     = 32'd0;
        tick();
        start_valid = 1'b0;
        chk("fdz.done", {result_valid, div_by_zero}, 2'b11);
        flush        = 1'b1;
        result_ready = 1'b1;
        tick();
        flush        = 1'b0;
        result_ready = 1'b0;
        chk("fdz.clear", {result_valid, div_by_zero, start_ready}, 3'b001);

        // Load a known result, then assert reset asynchronously mid-CALC
        run_div("pre_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
        start_valid = 1'b1;
        dividend    = 32'd1000;
        divisor     = 32'd3;
        tick();
        start_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.outs", {quotient, remainder, div_by_zero, result_valid, busy, start_ready},
            {32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_div("post_rst", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
